// File: rtl/spi_reg_bank.sv
// SPI mode-0 write-only slave that validates 16-bit frames and commits the data byte
// into one of five PWM control registers when chip-select deasserts.
module spi_reg_bank #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_copi_sync, r_ncs_sync;
  logic                   r_sclk_prev, r_ncs_prev;
  state_t                 r_state, w_state_nxt;
  logic [15:0]            r_shift, w_shift_nxt;
  logic [4:0]             r_cnt, w_cnt_nxt;
  logic                   r_ovr, w_ovr_nxt;
  logic                   w_commit;
  logic [4:0][7:0]        r_regs;

  logic w_sclk, w_copi, w_ncs;
  logic w_sclk_rise, w_ncs_fall, w_ncs_rise;

  // Sync flops reset to 0 so a chip-select held low through reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_sync  <= '0;
      r_sclk_prev <= 1'b0;
      r_ncs_prev  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_sclk_prev <= w_sclk;
      r_ncs_prev  <= w_ncs;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi      = r_copi_sync[SYNC_STAGES-1];
  assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_ncs_fall  = ~w_ncs & r_ncs_prev;
  assign w_ncs_rise  = w_ncs & ~r_ncs_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_ovr_nxt   = r_ovr;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ncs_fall) begin
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
          w_ovr_nxt   = 1'b0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_ncs_rise) begin
          w_state_nxt = CHECK;
        end else if (w_sclk_rise) begin
          // A 17th clock poisons the frame instead of shifting the header out.
          if (!r_cnt[4]) begin
            w_shift_nxt = {r_shift[14:0], w_copi};
            w_cnt_nxt   = r_cnt + 5'd1;
          end else begin
            w_ovr_nxt = 1'b1;
          end
        end
      end
      CHECK: begin
        w_commit    = (r_cnt == 5'd16) && !r_ovr && r_shift[15] && (r_shift[14:8] <= MAX_ADDR);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs <= '0;
    end else if (w_commit) begin
      case (r_shift[14:8])
        7'h00:   r_regs[0] <= r_shift[7:0];
        7'h01:   r_regs[1] <= r_shift[7:0];
        7'h02:   r_regs[2] <= r_shift[7:0];
        7'h03:   r_regs[3] <= r_shift[7:0];
        7'h04:   r_regs[4] <= r_shift[7:0];
        default: ;
      endcase
    end
  end

  assign en_reg_out_7_0  = r_regs[0];
  assign en_reg_out_15_8 = r_regs[1];
  assign en_reg_pwm_7_0  = r_regs[2];
  assign en_reg_pwm_15_8 = r_regs[3];
  assign pwm_duty_cycle  = r_regs[4];

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench: stimulus pushes expected register images and landing cycles,
// a monitor pops one entry each time the register outputs change.
module tb_spi_reg_bank;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
  logic [7:0] o0, o1, o2, o3, o4;

  spi_reg_bank dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(o0), .en_reg_out_15_8(o1), .en_reg_pwm_7_0(o2),
    .en_reg_pwm_15_8(o3), .pwm_duty_cycle(o4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] vec;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  m[5];
  int          cyc = 0;
  int          ntests = 0, nfail = 0;
  bit          mon_en = 1'b0;
  wire  [39:0] dut_vec = {o4, o3, o2, o1, o0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [39:0] model_vec();
    return {m[4], m[3], m[2], m[1], m[0]};
  endfunction

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every change of the register outputs must match the oldest expectation.
  initial begin
    logic [39:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && dut_vec !== prev) begin
        if (q.size() == 0) begin
          ntests++;
          nfail++;
          $display("FAIL spurious_update: got %h at cycle %0d expected no change", dut_vec, cyc);
        end else begin
          e = q.pop_front();
          chk({e.name, "_value"}, dut_vec, e.vec);
          ntests++;
          if (cyc != e.cyc) begin
            nfail++;
            $display("FAIL %s_latency: got cycle %0d expected cycle %0d", e.name, cyc, e.cyc);
          end
        end
      end
      prev = dut_vec;
    end
  end

  task automatic pulse_rst();
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    foreach (m[i]) m[i] = 8'h00;
    e.vec = '0; e.cyc = cyc + 1; e.name = "mid_frame_reset";
    q.push_back(e);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Send nbits of word MSB first; optionally reset after bit index rst_after has been clocked.
  task automatic send(input logic [16:0] word, input int nbits, input bit commit,
                      input int gap, input int rst_after, input string nm);
    exp_t e;
    @(negedge clk);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = word[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      if (i == rst_after) pulse_rst();
    end
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    if (commit) begin
      m[int'(word[14:8])] = word[7:0];
      e.vec = model_vec(); e.cyc = cyc + 4; e.name = nm;
      q.push_back(e);
    end
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    foreach (m[i]) m[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", dut_vec, 40'h0);
    mon_en = 1'b1;

    send(17'h080F0, 16, 1, 8, -1, "wr_r0");
    send(17'h0810F, 16, 1, 8, -1, "wr_r1");
    send(17'h082AA, 16, 1, 8, -1, "wr_r2");
    send(17'h08355, 16, 1, 8, -1, "wr_r3");
    send(17'h08480, 16, 1, 8, -1, "wr_r4");
    repeat (6) @(negedge clk);
    chk("all_writes", dut_vec, 40'h80_55_AA_0F_F0);

    send(17'h00512, 16, 0, 8, -1, "read_frame");
    send(17'h08512, 16, 0, 8, -1, "addr_over_max");
    chk("discard_read_and_addr", dut_vec, 40'h80_55_AA_0F_F0);

    send(17'h04219, 15, 0, 8, -1, "short_frame");
    chk("short_frame", dut_vec, model_vec());
    send(17'h10867, 17, 0, 8, -1, "long_frame");
    chk("long_frame", dut_vec, model_vec());
    send(17'h08433, 16, 1, 8, -1, "wr_r4_33");
    repeat (6) @(negedge clk);
    chk("after_33", dut_vec, 40'h33_55_AA_0F_F0);

    send(17'h08477, 16, 0, 8, 8, "reset_frame");
    repeat (6) @(negedge clk);
    chk("after_mid_reset", dut_vec, 40'h0);
    send(17'h08477, 16, 1, 8, -1, "wr_r4_77");

    repeat (16) begin
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk("idle_sclk", dut_vec, 40'h77_00_00_00_00);
    send(17'h0823C, 16, 1, 8, -1, "wr_r2_3c");
    repeat (6) @(negedge clk);
    chk("after_3c", dut_vec, 40'h77_00_3C_00_00);

    send(17'h08001, 16, 1, 3, -1, "b2b_first");
    send(17'h08002, 16, 1, 8, -1, "b2b_second");

    for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge clk);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      ntests++;
      nfail++;
      $display("FAIL %s_timeout: got no update expected %h by cycle %0d", e.name, e.vec, e.cyc);
    end
    chk("final_state", dut_vec, 40'h77_00_3C_00_02);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
